// File: rtl/core_out_uart.sv
// core_out_uart: watches the core result bus, queues every new value in a
// small FIFO and streams each one off-chip as two 8N1 UART bytes:
// {4'hA, 2'b00, d[9:8]} followed by d[7:0].
`timescale 1ns/1ps

module core_out_uart #(
    parameter int DATA_W       = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W-1:0]                  out_in,
    output logic                               tx,
    output logic                               busy,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Change detector and FIFO handshake
    logic [DATA_W-1:0] last_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;
    logic              accept;

    // Serializer state and datapath (current / next)
    state_t            state, state_d;
    logic              tx_q, tx_d;
    logic [7:0]        sh_q, sh_d;
    logic [7:0]        hold_q, hold_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              sel_q, sel_d;
    logic              baud_last;

    assign push      = (out_in != last_q);
    assign pop       = (state == IDLE) && (fifo_count != '0);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign accept    = push && ((fifo_count != CNT_W'(FIFO_DEPTH)) || pop);
    assign head      = mem[rd_ptr];
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    assign tx   = tx_q;
    assign busy = (fifo_count != '0) || (state != IDLE);

    // Track the last seen bus value; every difference is a push request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= '0;
        end else if (push) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            last_q <= out_in;
        end
    end

    // FIFO storage writes.
    // NOTE: the data array has no reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= out_in;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    // Serializer registers; tx comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            tx_q   <= 1'b1;
            sh_q   <= '0;
            hold_q <= '0;
            baud_q <= '0;
            bit_q  <= '0;
            sel_q  <= 1'b0;
        end else begin
            state  <= state_d;
            tx_q   <= tx_d;
            sh_q   <= sh_d;
            hold_q <= hold_d;
            baud_q <= baud_d;
            bit_q  <= bit_d;
            sel_q  <= sel_d;
        end
    end

    // Serializer next state: bit timing, shifting and byte sequencing.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d = state;
        tx_d    = tx_q;
        sh_d    = sh_q;
        hold_d  = hold_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sel_d   = sel_q;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_count != '0) begin
                    hold_d  = head[7:0];
                    sh_d    = {4'hA, 2'b00, head[9:8]};
                    sel_d   = 1'b0;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!sel_q) begin
                        // Second byte starts right after the first stop bit.
                        sh_d    = hold_q;
                        sel_d   = 1'b1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_out_uart.sv
// Directed bench for core_out_uart with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_core_out_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] out_in = '0;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [2:0]    fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_out_uart #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .out_in    (out_in),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a start bit, then checks all 80 cycles of a
    // two-byte frame against the expected line pattern and decodes both bytes
    // from mid-bit samples. Returns on the falling edge after the last stop bit.
    task automatic check_frame(input string tag, input logic [7:0] b0,
                               input logic [7:0] b1, output int busy_hi);
        logic [19:0] bits;
        logic [7:0]  r0;
        logic [7:0]  r1;
        int          bad;
        int          waited;
        int          k;
        bits    = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
        r0      = '0;
        r1      = '0;
        bad     = 0;
        busy_hi = 0;
        waited  = 0;
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            chk({tag, "_start_timeout"}, {31'd0, tx}, 32'd0);
            return;
        end
        for (int c = 0; c < 20 * CPB; c++) begin
            k = c / CPB;
            if (tx !== bits[k]) bad++;
            if (c % CPB == CPB / 2) begin
                if (k >= 1 && k <= 8)   r0[k-1]  = tx;
                if (k >= 11 && k <= 18) r1[k-11] = tx;
            end
            if (busy === 1'b1) busy_hi++;
            @(negedge clk);
        end
        chk({tag, "_byte0"}, {24'd0, r0}, {24'd0, b0});
        chk({tag, "_byte1"}, {24'd0, r1}, {24'd0, b1});
        chk({tag, "_bit_timing"}, bad, 0);
    endtask

    initial begin
        int bh;
        int dummy;
        int peak;
        int low_cnt;
        int s;

        // ---------------- reset state ----------------
        reset  = 1'b0;
        out_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("zero_no_push_count", {29'd0, fifo_count}, 32'd0);
        chk("zero_no_push_busy", {31'd0, busy}, 32'd0);

        // ---------------- single value 45 ----------------
        out_in = DW'(45);
        @(negedge clk);
        chk("single_count_after_push", {29'd0, fifo_count}, 32'd1);
        chk("single_tx_at_push", {31'd0, tx}, 32'd1);
        chk("single_busy_at_push", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("single_tx_falls", {31'd0, tx}, 32'd0);
        chk("single_count_popped", {29'd0, fifo_count}, 32'd0);
        check_frame("single", 8'hA0, 8'h2D, bh);
        chk("single_busy_cycles", bh + 1, 81);
        chk("single_busy_end", {31'd0, busy}, 32'd0);
        chk("single_overflow", {31'd0, overflow}, 32'd0);
        low_cnt = 0;
        repeat (110) begin
            if (tx !== 1'b1 || busy !== 1'b0) low_cnt++;
            @(negedge clk);
        end
        chk("single_quiet_after", low_cnt, 0);

        // ---------------- top bits 0x3FF ----------------
        out_in = DW'(10'h3FF);
        check_frame("top", 8'hA3, 8'hFF, dummy);

        // ---------------- burst 1..6 ----------------
        peak = 0;
        fork
            begin
                for (int v = 1; v <= 6; v++) begin
                    out_in = DW'(v);
                    @(negedge clk);
                    if (int'(fifo_count) > peak) peak = int'(fifo_count);
                end
                @(negedge clk);
                if (int'(fifo_count) > peak) peak = int'(fifo_count);
            end
            begin
                check_frame("burst_v1", 8'hA0, 8'h01, dummy);
            end
        join
        chk("burst_peak_count", peak, 4);
        chk("burst_overflow", {31'd0, overflow}, 32'd1);
        check_frame("burst_v2", 8'hA0, 8'h02, dummy);
        check_frame("burst_v3", 8'hA0, 8'h03, dummy);
        check_frame("burst_v4", 8'hA0, 8'h04, dummy);
        check_frame("burst_v5", 8'hA0, 8'h05, dummy);
        repeat (100) @(negedge clk);
        chk("burst_v6_dropped_tx", {31'd0, tx}, 32'd1);
        chk("burst_v6_dropped_busy", {31'd0, busy}, 32'd0);
        chk("burst_overflow_sticky", {31'd0, overflow}, 32'd1);

        // ---------------- no change ----------------
        out_in = DW'(7);
        check_frame("steady", 8'hA0, 8'h07, dummy);
        low_cnt = 0;
        repeat (500) begin
            if (tx !== 1'b1 || busy !== 1'b0) low_cnt++;
            @(negedge clk);
        end
        chk("steady_no_frames", low_cnt, 0);
        chk("steady_overflow_kept", {31'd0, overflow}, 32'd1);

        // ---------------- reset mid-frame ----------------
        out_in = DW'(8);
        @(negedge clk);
        out_in = DW'(9);
        @(negedge clk);
        out_in = DW'(10);
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("midrst_queued", {29'd0, fifo_count}, 32'd2);
        chk("midrst_tx_data_bit", {31'd0, tx}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_count", {29'd0, fifo_count}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_frame("midrst_refill", 8'hA0, 8'h0A, dummy);
        low_cnt = 0;
        repeat (200) begin
            if (tx !== 1'b1 || busy !== 1'b0) low_cnt++;
            @(negedge clk);
        end
        chk("midrst_single_frame", low_cnt, 0);

        // ---------------- core-style running sum ----------------
        reset  = 1'b0;
        out_in = '0;
        #200;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        s = 0;
        for (int i = 1; i <= 9; i++) begin
            s      = s + i;
            out_in = DW'(s);
            check_frame($sformatf("core_sum_%0d", s), 8'hA0, 8'(s), dummy);
        end
        chk("core_final_busy", {31'd0, busy}, 32'd0);
        chk("core_overflow", {31'd0, overflow}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_out_uart.md
# core_out_uart

Downstream consumer of the core's 10-bit `out` result bus. It detects every change of the core result, queues the new values in a small FIFO, and serializes each one as a two-byte 8N1 UART frame on a single `tx` pin. This lets post-synthesis and on-board runs stream the core's result sequence (for example, the running sum ending at 45) off-chip without probing the internal bus.

## Interface
Parameters:
- `DATA_W`, 10: width of the monitored core result bus. Fixed at 10 for the current byte format.
- `CLKS_PER_BIT`, 16: `clk` cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: number of queued result entries. Must be a power of 2.

Ports:
- `clk`  in  1: single clock. Every flop is rising-edge on `clk`.
- `reset`  in  1: asynchronous, active-low reset. Assertion (0) clears all state immediately. Deassertion is synchronous to `clk` at the system level.
- `out_in`  in  `DATA_W`: core result bus, connected directly to `core.out`.
- `tx`  out  1: UART serial output. Idles high.
- `busy`  out  1: high when the FIFO is non-empty or the serializer is not in IDLE.
- `overflow`  out  1: sticky. Set when a change is dropped because the FIFO is full. Cleared only by reset.
- `fifo_count`  out  `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.

## Operation
- Change detect:
  - Register `last_q` (reset 0).
  - At each edge where `out_in != last_q`, `last_q <= out_in` and a push request is raised for `out_in`.
  - A steady bus produces no push. A value equal to 0 after reset produces no push.
- FIFO:
  - Circular buffer with read and write pointers and a count.
  - A push is accepted when `fifo_count < FIFO_DEPTH`, or when a pop occurs in the same cycle. A simultaneous push and pop on a full FIFO keeps the count at `FIFO_DEPTH` and loses no data.
  - Otherwise the push is dropped and `overflow <= 1`. `last_q` still updates.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Frame format per value `d`:
  - byte0 = {4'hA, 2'b00, d[9:8]}.
  - byte1 = d[7:0].
  - Each byte is 8N1: start bit 0, data bits LSB first, stop bit 1.
- Serializer FSM states: IDLE, START, DATA, STOP, plus a `byte_sel` flag and a bit counter `0..7`.
  - IDLE: `tx` = 1. If `fifo_count != 0`, pop the head, load the byte0 shift register, set `byte_sel` = 0, `tx <= 0`, and go to START.
  - START: holds for `CLKS_PER_BIT` cycles, then goes to DATA with `tx` = bit0.
  - DATA: each bit holds for `CLKS_PER_BIT` cycles. After bit7 completes, go to STOP with `tx` = 1.
  - STOP: holds for `CLKS_PER_BIT` cycles.
    - If `byte_sel` = 0: load byte1 from the held value, set `byte_sel` = 1, `tx <= 0`, and go to START. There is no gap between bytes.
    - Else: go to IDLE.
- `tx` is driven from a flop, with no combinational path from `out_in`.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `overflow` = 0, `fifo_count` = 0, FSM = IDLE, `last_q` = 0, pointers = 0.
- Push latency:
  - A change present at edge N is written at edge N; `fifo_count` reflects it after edge N.
  - With the FIFO previously empty and the FSM in IDLE, the pop occurs at edge N+1 and `tx` falls after edge N+1.
- One value occupies the line for 20 × `CLKS_PER_BIT` cycles.
- IDLE lasts at least 1 cycle between values, so the last stop bit is `CLKS_PER_BIT`+1 cycles when the next value is queued.
- Bit boundaries are exact: every bit holds exactly `CLKS_PER_BIT` cycles.
- Sustained input faster than one change per 20 × `CLKS_PER_BIT` cycles fills the FIFO and then sets `overflow`. This is an accepted condition, not an error stop.
- Reset asserted mid-frame: `tx` returns to 1 asynchronously, the queued values are discarded, and `overflow` clears. After release the block behaves as from power-up.

## Test plan
Run with `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.
- **Single value:** release reset with `out_in` = 0, then drive `out_in` = 45 for 200 cycles.
  - Exactly one frame: 0xA0 then 0x2D on `tx`.
  - `tx` falls one cycle after the push edge.
  - `busy` is high for 81 cycles, `fifo_count` returns to 0, `overflow` stays 0.
- **Top bits:** drive `out_in` = 0x3FF.
  - Frames: 0xA3 then 0xFF.
  - Each bit measured at exactly 4 cycles. The second start bit directly follows the first stop bit.
- **Burst:** change `out_in` on 6 consecutive cycles through 1, 2, 3, 4, 5, 6.
  - Values 1 through 5 are transmitted in order, 6 is dropped.
  - `overflow` = 1 and stays set. Peak `fifo_count` = 4.
- **No change:** hold `out_in` = 7 for 500 cycles after its first frame completes.
  - No further frames. `tx` stays 1.
- **Reset mid-frame:** pull `reset` low during the DATA state of byte0 with 2 entries queued.
  - `tx` = 1, `fifo_count` = 0, and `busy` = 0 immediately.
  - After release with a steady nonzero `out_in`, exactly one new frame is sent for that value.
- **Core-driven run:** connect the core and apply its reset sequence (reset held for 200 time units).
  - The decoded frame sequence matches the core's `out` change sequence, ending with 45.
